// File: rtl/calc_alu_n_if.sv
// Block-level ap_* handshake and operand/result bundle
// for the calc_alu_n compute leaf.
interface calc_alu_n_if #(
  parameter int W = 32
);
  logic         ap_start;
  logic         ap_done;
  logic         ap_idle;
  logic         ap_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic [W-1:0] thresh;
  logic [W-1:0] ap_return;
  logic [1:0]   ap_flags;

  modport master (
    output ap_start, a, b, op, thresh,
    input  ap_done, ap_idle, ap_ready,
    input  ap_return, ap_flags
  );

  modport slave (
    input  ap_start, a, b, op, thresh,
    output ap_done, ap_idle, ap_ready,
    output ap_return, ap_flags
  );
endinterface

// File: rtl/calc_alu_n.sv
// Signed W-bit add/sub/mul unit with legacy threshold mode
// and a fixed-latency multiply path.
module calc_alu_n #(
  parameter int W       = 32,
  parameter int MUL_LAT = 2
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  calc_alu_n_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_t;

  localparam int CW =
    (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(MUL_LAT - 1);

  state_t r_state;
  state_t w_next;

  logic signed [W-1:0] r_a;
  logic signed [W-1:0] r_b;
  logic signed [W-1:0] r_th;
  logic [1:0]          r_op;
  logic [CW-1:0]       r_cnt;
  logic [W-1:0]        r_ret;
  logic [1:0]          r_flags;

  logic signed [W-1:0]   w_s;
  logic                  w_ovf_s;
  logic                  w_gt;
  logic                  w_take_sum;
  logic [2*W-1:0]        w_prod;
  logic [W:0]            w_phi;
  logic                  w_ovf_m;
  logic                  w_mul_last;
  logic                  w_is_sub;

  assign w_is_sub = (r_op == 2'b10);
  assign w_s = w_is_sub ? (r_a - r_b)
                        : (r_a + r_b);

  // Overflow: operands agree in sign (add) or differ (sub)
  // and the wrapped result flips away from a's sign.
  assign w_ovf_s =
    ((r_a[W-1] ^ r_b[W-1]) == w_is_sub) &&
    (w_s[W-1] != r_a[W-1]);

  assign w_gt = (w_s > r_th);

  always_comb begin
    w_take_sum = 1'b0;
    unique case (1'b1)
      (r_op == 2'b01): w_take_sum = 1'b1;
      (r_op == 2'b10): w_take_sum = 1'b1;
      (r_op == 2'b00): w_take_sum = w_gt;
      (r_op == 2'b11): w_take_sum = 1'b0;
      default:         w_take_sum = 1'b0;
    endcase
  end

  assign w_prod =
    {{W{r_a[W-1]}}, r_a} * {{W{r_b[W-1]}}, r_b};
  assign w_phi   = w_prod[2*W-1:W-1];
  assign w_ovf_m = !((&w_phi) || !(|w_phi));

  assign w_mul_last =
    (r_state == S_MUL) && (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.ap_start) w_next = S_EXEC;
      S_EXEC:
        w_next = w_take_sum ? S_DONE : S_MUL;
      S_MUL:
        if (w_mul_last) w_next = S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_th    <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_ret   <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.ap_start) begin
        r_a  <= bus.a;
        r_b  <= bus.b;
        r_op <= bus.op;
        r_th <= bus.thresh;
      end
      if (r_state == S_MUL && !w_mul_last)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
      if (r_state == S_EXEC && w_take_sum) begin
        r_ret   <= w_s;
        r_flags <= {(r_op == 2'b00), w_ovf_s};
      end else if (w_mul_last) begin
        r_ret   <= w_prod[W-1:0];
        r_flags <= {1'b0, w_ovf_m};
      end
    end
  end

  assign bus.ap_done   = (r_state == S_DONE);
  assign bus.ap_ready  = (r_state == S_DONE);
  assign bus.ap_idle   =
    (r_state == S_IDLE) && !bus.ap_start;
  assign bus.ap_return = r_ret;
  assign bus.ap_flags  = r_flags;

endmodule

// File: tb/tb_calc_alu_n.sv
// Vector table, random ops against a reference model,
// and hand-built reset / back-to-back sequences.
module tb_calc_alu_n;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  calc_alu_n_if #(.W(W)) bus ();

  calc_alu_n #(.W(W), .MUL_LAT(LAT)) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] th;
    logic [31:0] ret;
    logic [1:0]  fl;
    int          lat;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic inrange(input longint v);
    return (v >= -64'sd2147483648) &&
           (v <= 64'sd2147483647);
  endfunction

  function automatic void model(
    input  logic [31:0] a, b, th,
    input  logic [1:0]  op,
    output logic [31:0] r,
    output logic [1:0]  f,
    output int          lat);
    longint sa, sb, s, p;
    logic [63:0] sv, pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = (op == 2'b10) ? sa - sb : sa + sb;
    p  = sa * sb;
    sv = s;
    pv = p;
    if (op == 2'b01 || op == 2'b10) begin
      r = sv[31:0]; f = {1'b0, !inrange(s)}; lat = 2;
    end else if (op == 2'b00 &&
                 $signed(sv[31:0]) > $signed(th)) begin
      r = sv[31:0]; f = {1'b1, !inrange(s)}; lat = 2;
    end else begin
      r = pv[31:0]; f = {1'b0, !inrange(p)};
      lat = 2 + LAT;
    end
  endfunction

  task automatic run_op(
    input logic [31:0] a, b, th,
    input logic [1:0]  op,
    input logic [31:0] er,
    input logic [1:0]  ef,
    input int          el,
    input bit          scr);
    int k;
    bit got;
    logic [31:0] held;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.op = op;
    bus.thresh = th; bus.ap_start = 1'b1;
    #1 chk("idle_falls", bus.ap_idle, 1'b0);
    @(posedge clk);
    k = 0; got = 0;
    while (k < 40 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) bus.ap_start = 1'b0;
      if (bus.ap_done) got = 1;
      else if (scr) begin
        bus.a = $urandom; bus.b = $urandom;
        bus.op = 2'($urandom);
        bus.thresh = $urandom;
      end
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("latency", 64'(k), 64'(el));
    chk("ready", bus.ap_ready, 1'b1);
    chk("ret", bus.ap_return, er);
    chk("flags", bus.ap_flags, ef);
    held = bus.ap_return;
    @(negedge clk);
    chk("done_pulse", bus.ap_done, 1'b0);
    chk("idle_after", bus.ap_idle, 1'b1);
    @(negedge clk);
    chk("ret_hold", bus.ap_return, held);
  endtask

  initial begin
    logic [31:0] ra, rb, rt, mr;
    logic [1:0]  rop, mf;
    int          ml;

    vt[0] = '{32'd600, 32'd500, 2'b00, 32'd1000,
              32'd1100, 2'b10, 2};
    vt[1] = '{32'd3, 32'd4, 2'b00, 32'd1000,
              32'd12, 2'b00, 2 + LAT};
    vt[2] = '{32'd3, 32'd4, 2'b00, -32'sd1000,
              32'd7, 2'b10, 2};
    vt[3] = '{32'h8000_0000, 32'd1, 2'b10, 32'd0,
              32'h7FFF_FFFF, 2'b01, 2};
    vt[4] = '{32'h7FFF_FFFF, 32'd1, 2'b01, 32'd0,
              32'h8000_0000, 2'b01, 2};
    vt[5] = '{32'h0001_0000, 32'h0001_0000, 2'b11,
              32'd0, 32'd0, 2'b01, 2 + LAT};
    vt[6] = '{-32'sd3, 32'd5, 2'b11, 32'd0,
              -32'sd15, 2'b00, 2 + LAT};
    vt[7] = '{32'd5, 32'd5, 2'b00, 32'd10,
              32'd25, 2'b00, 2 + LAT};
    vt[8] = '{32'h7FFF_FFFF, 32'd1, 2'b00,
              32'h8000_0000, 32'h7FFF_FFFF, 2'b00,
              2 + LAT};
    vt[9] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b11,
              32'd0, 32'h8000_0000, 2'b01, 2 + LAT};

    rst = 1'b1;
    bus.ap_start = 1'b0;
    bus.a = '0; bus.b = '0;
    bus.op = '0; bus.thresh = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", bus.ap_done, 1'b0);
    chk("rst_ready", bus.ap_ready, 1'b0);
    chk("rst_ret", bus.ap_return, 32'd0);
    chk("rst_flags", bus.ap_flags, 2'b00);
    chk("rst_idle", bus.ap_idle, 1'b1);
    bus.ap_start = 1'b1;
    #1 chk("rst_idle_start", bus.ap_idle, 1'b0);
    @(negedge clk);
    bus.ap_start = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vt[i].a, vt[i].b, vt[i].th, vt[i].op,
             vt[i].ret, vt[i].fl, vt[i].lat, 1'b1);

    for (int i = 0; i < 60; i++) begin
      ra  = (i % 3 == 0) ? 32'($urandom_range(0, 200))
                         : $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 200))
                         : $urandom;
      rt  = (i % 2 == 0) ? 32'($urandom_range(0, 400))
                         : $urandom;
      rop = 2'($urandom);
      model(ra, rb, rt, rop, mr, mf, ml);
      run_op(ra, rb, rt, rop, mr, mf, ml, i[0]);
    end

    // back-to-back adds with ap_start held high
    @(negedge clk);
    bus.a = 32'd1; bus.b = 32'd2; bus.op = 2'b01;
    bus.ap_start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.a = 32'd3; bus.b = 32'd4;
      end
      chk("b2b_done", bus.ap_done,
          (k == 2 || k == 5));
      if (k <= 5)
        chk("b2b_idle", bus.ap_idle, 1'b0);
      if (k == 2) chk("b2b_ret1", bus.ap_return, 32'd3);
      if (k == 5) begin
        chk("b2b_ret2", bus.ap_return, 32'd7);
        bus.ap_start = 1'b0;
      end
    end

    // reset in the first MUL cycle aborts the request
    @(negedge clk);
    bus.a = 32'd3; bus.b = 32'd5; bus.op = 2'b11;
    bus.ap_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ap_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_done", bus.ap_done, 1'b0);
    chk("mrst_ret", bus.ap_return, 32'd0);
    chk("mrst_flags", bus.ap_flags, 2'b00);
    chk("mrst_idle", bus.ap_idle, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mrst_nodone", bus.ap_done, 1'b0);
    end

    // reset concurrent with start: no request taken
    bus.a = 32'd9; bus.b = 32'd9; bus.op = 2'b01;
    bus.ap_start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ap_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("crst_nodone", bus.ap_done, 1'b0);
      chk("crst_idle", bus.ap_idle, 1'b1);
    end
    chk("crst_ret", bus.ap_return, 32'd0);

    run_op(32'd10, 32'd4, 32'd0, 2'b10,
           32'd6, 2'b00, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
